// File: rtl/wb_pkg.sv
// Shared definitions for the MIPS write-back stage: FSM encoding, load-size
// codes, default widths and the load-data timeout limit.
package wb_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_ADDR_W  = 5;
  localparam int WB_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;

  // Code 2'b11 is not listed because it decodes as a word load.
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  typedef struct packed {
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] off;
  } ld_ctrl_t;

endpackage

// File: rtl/writeback_if.sv
// Memory-stage to write-back handshake: the retiring instruction fields plus
// the late-arriving load data word.
interface writeback_if
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic              in_wen;
  logic              in_mem_to_reg;
  logic [1:0]        in_ld_size;
  logic              in_ld_unsigned;
  logic [1:0]        in_byte_off;
  logic [DATA_W-1:0] in_alu;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output in_valid, in_rd, in_wen, in_mem_to_reg, in_ld_size,
           in_ld_unsigned, in_byte_off, in_alu, mem_data_valid, mem_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_wen, in_mem_to_reg, in_ld_size,
           in_ld_unsigned, in_byte_off, in_alu, mem_data_valid, mem_data,
    output in_ready
  );

endinterface

// File: rtl/writeback_load_align.sv
// Little-endian lane select and sign/zero extension for sub-word loads.
// Purely combinational.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_off,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_data[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_data[16 +: 16] : i_data[0 +: 16];

  always_comb begin
    unique case (i_size)
      LD_HALF: o_data = {{(DATA_W-16){~i_unsigned & w_half[15]}}, w_half};
      LD_BYTE: o_data = {{(DATA_W-8){~i_unsigned & w_byte[7]}}, w_byte};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// MIPS write-back stage: retires instructions, waits for load data, drives the
// register-bank write port and the same-cycle bypass. Option: WB_TIMEOUT_EN.
module writeback
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              reloj,
  input  logic              reset_n,
  writeback_if.slave        bus,
  output logic [ADDR_W-1:0] DIR_WRA,
  output logic [DATA_W-1:0] DI,
  output logic              REG_WR,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dir,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy,
  output logic              wb_err
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_dir;
  logic [DATA_W-1:0] r_di;
  logic [ADDR_W-1:0] r_pend_rd;
  ld_ctrl_t          r_ld;
  logic              w_accept;
  logic              w_silent;
  logic              w_mem_hit;
  logic              w_timeout;
  logic [DATA_W-1:0] w_aligned;

  load_align #(.DATA_W(DATA_W)) u_align (
    .i_data     (bus.mem_data),
    .i_size     (r_ld.size),
    .i_off      (r_ld.off),
    .i_unsigned (r_ld.is_unsigned),
    .o_data     (w_aligned)
  );

  assign bus.in_ready = (r_state != ST_WAIT_MEM);
  assign w_accept     = bus.in_valid & bus.in_ready;
  // Writes to r0 are dropped here, so the strobe can never address it.
  assign w_silent     = ~bus.in_wen | (bus.in_rd == '0);
  assign w_mem_hit    = (r_state == ST_WAIT_MEM) & bus.mem_data_valid;

`ifdef WB_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;
  logic       r_err;

  assign w_timeout = (r_state == ST_WAIT_MEM) & ~bus.mem_data_valid &
                     (r_tmo_cnt == 4'(WB_TIMEOUT - 1));
  assign wb_err    = r_err;

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == ST_WAIT_MEM) ? r_tmo_cnt + 4'd1 : 4'd0;
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign wb_err    = 1'b0;
`endif

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = ST_IDLE;
    if (r_state == ST_WAIT_MEM) begin
      if (bus.mem_data_valid) w_next = ST_COMMIT;
      else if (w_timeout)     w_next = ST_IDLE;
      else                    w_next = ST_WAIT_MEM;
    end else if (w_accept && !w_silent) begin
      w_next = bus.in_mem_to_reg ? ST_WAIT_MEM : ST_COMMIT;
    end
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_dir     <= '0;
      r_di      <= '0;
      r_pend_rd <= '0;
      r_ld      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      // A load keeps its target aside so DIR_WRA/DI hold through WAIT_MEM.
      if (w_accept && !w_silent) begin
        if (bus.in_mem_to_reg) begin
          r_pend_rd <= bus.in_rd;
          r_ld      <= '{size: bus.in_ld_size, is_unsigned: bus.in_ld_unsigned,
                         off: bus.in_byte_off};
        end else begin
          r_dir <= bus.in_rd;
          r_di  <= bus.in_alu;
        end
      end
      if (w_mem_hit) begin
        r_dir <= r_pend_rd;
        r_di  <= w_aligned;
      end
    end
  end

  assign DIR_WRA   = r_dir;
  assign DI        = r_di;
  assign REG_WR    = (r_state != ST_COMMIT);
  assign fwd_valid = (r_state == ST_COMMIT);
  assign fwd_dir   = r_dir;
  assign fwd_data  = r_di;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed cases followed by random
// traffic scored against a queue of expected register-bank writes.
module tb_writeback;

  logic        reloj;
  logic        reset_n;
  logic [4:0]  DIR_WRA;
  logic [31:0] DI;
  logic        REG_WR;
  logic        fwd_valid;
  logic [4:0]  fwd_dir;
  logic [31:0] fwd_data;
  logic        busy;
  logic        wb_err;

  writeback_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  writeback #(.DATA_W(32), .ADDR_W(5)) dut (
    .reloj     (reloj),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .DIR_WRA   (DIR_WRA),
    .DI        (DI),
    .REG_WR    (REG_WR),
    .fwd_valid (fwd_valid),
    .fwd_dir   (fwd_dir),
    .fwd_data  (fwd_data),
    .busy      (busy),
    .wb_err    (wb_err)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          strobes   = 0;
  int          exp_total = 0;
  logic [4:0]  pend_rd;
  logic [1:0]  pend_size;
  logic        pend_uns;
  logic [1:0]  pend_off;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [1:0] size,
                                            input logic uns, input logic [1:0] off);
    logic [31:0] v;
    if (size == 2'b10) begin
      v = (d >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (d >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Advance one clock and score any write strobe seen in the new cycle.
  task automatic tick();
    wr_t e;
    @(posedge reloj);
    #1;
    if (REG_WR === 1'b0) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, REG_WR}, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_dir", DIR_WRA, e.rd);
        check("wr_data", DI, e.data);
        check("fwd_valid", fwd_valid, 1'b1);
        check("fwd_dir", fwd_dir, e.rd);
        check("fwd_data", fwd_data, e.data);
      end
    end else begin
      check("fwd_idle", fwd_valid, 1'b0);
    end
  endtask

  task automatic send(input logic [4:0] rd, input logic wen, input logic m2r,
                      input logic [1:0] size, input logic uns, input logic [1:0] off,
                      input logic [31:0] alu);
    bus.in_rd          = rd;
    bus.in_wen         = wen;
    bus.in_mem_to_reg  = m2r;
    bus.in_ld_size     = size;
    bus.in_ld_unsigned = uns;
    bus.in_byte_off    = off;
    bus.in_alu         = alu;
    bus.in_valid       = 1'b1;
    // Load data offered in the accept cycle must be ignored.
    bus.mem_data_valid = m2r;
    bus.mem_data       = $urandom;
    if (wen && rd != 5'd0) begin
      if (m2r) begin
        pend_rd = rd; pend_size = size; pend_uns = uns; pend_off = off;
      end else begin
        exp_q.push_back('{rd, alu});
        exp_total++;
      end
    end
    tick();
    bus.in_valid       = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.in_alu         = $urandom;
    bus.in_rd          = 5'($urandom);
  endtask

  task automatic give_mem(input logic [31:0] data, input int delay);
    for (int i = 0; i < delay; i++) begin
      check("wait_ready", bus.in_ready, 1'b0);
      check("wait_busy", busy, 1'b1);
      bus.mem_data_valid = 1'b0;
      bus.mem_data       = $urandom;
      tick();
    end
    check("wait_ready", bus.in_ready, 1'b0);
    bus.mem_data_valid = 1'b1;
    bus.mem_data       = data;
    exp_q.push_back('{pend_rd, ref_align(data, pend_size, pend_uns, pend_off)});
    exp_total++;
    tick();
    bus.mem_data_valid = 1'b0;
    check("load_strobe", REG_WR, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  rd;
    logic        wen, m2r, uns;
    logic [1:0]  size, off;

    reset_n            = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_rd          = '0;
    bus.in_wen         = 1'b0;
    bus.in_mem_to_reg  = 1'b0;
    bus.in_ld_size     = '0;
    bus.in_ld_unsigned = 1'b0;
    bus.in_byte_off    = '0;
    bus.in_alu         = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = '0;

    #1;
    check("rst_reg_wr", REG_WR, 1'b1);
    check("rst_di", DI, 32'd0);
    check("rst_dir", DIR_WRA, 5'd0);
    check("rst_fwd_valid", fwd_valid, 1'b0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_fwd_dir", fwd_dir, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", bus.in_ready, 1'b1);
    check("rst_wb_err", wb_err, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // ALU op: strobe exactly one cycle after accept, then released.
    send(5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h1234_5678);
    check("alu_reg_wr", REG_WR, 1'b0);
    check("alu_dir", DIR_WRA, 5'd5);
    check("alu_di", DI, 32'h1234_5678);
    check("alu_fwd_valid", fwd_valid, 1'b1);
    tick();
    check("alu_release", REG_WR, 1'b1);
    check("alu_hold_di", DI, 32'h1234_5678);
    check("alu_idle_busy", busy, 1'b0);

    // Signed and unsigned byte loads, data three cycles after accept.
    send(5'd7, 1'b1, 1'b1, 2'b10, 1'b0, 2'd2, 32'h0);
    check("ld_hold_dir", DIR_WRA, 5'd5);
    give_mem(32'h0080_0000, 2);
    check("sbyte_di", DI, 32'hFFFF_FF80);
    tick();
    send(5'd7, 1'b1, 1'b1, 2'b10, 1'b1, 2'd2, 32'h0);
    give_mem(32'h0080_0000, 2);
    check("ubyte_di", DI, 32'h0000_0080);
    tick();

    // Half and word loads with offsets that must be partly or fully ignored.
    send(5'd9, 1'b1, 1'b1, 2'b01, 1'b0, 2'd2, 32'h0);
    give_mem(32'h8001_7FFF, 0);
    check("shalf_di", DI, 32'hFFFF_8001);
    send(5'd9, 1'b1, 1'b1, 2'b01, 1'b1, 2'd3, 32'h0);
    give_mem(32'h8001_7FFF, 1);
    check("uhalf_off3_di", DI, 32'h0000_8001);
    send(5'd10, 1'b1, 1'b1, 2'b00, 1'b0, 2'd3, 32'h0);
    give_mem(32'hDEAD_BEEF, 1);
    check("word_di", DI, 32'hDEAD_BEEF);
    send(5'd10, 1'b1, 1'b1, 2'b11, 1'b0, 2'd1, 32'h0);
    give_mem(32'hCAFE_F00D, 0);
    check("size3_word_di", DI, 32'hCAFE_F00D);
    tick();

    // Back-to-back ALU ops: one strobe per cycle, no bubble.
    send(5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'hA1);
    check("b2b_dir1", DIR_WRA, 5'd1);
    send(5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'hA2);
    check("b2b_strobe2", REG_WR, 1'b0);
    check("b2b_dir2", DIR_WRA, 5'd2);
    send(5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'hA3);
    check("b2b_strobe3", REG_WR, 1'b0);
    check("b2b_dir3", DIR_WRA, 5'd3);
    tick();
    check("b2b_release", REG_WR, 1'b1);

    // Silent retirements: r0 targets and wen=0.
    send(5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'hBAD0);
    check("r0_no_strobe", REG_WR, 1'b1);
    check("r0_busy", busy, 1'b0);
    send(5'd9, 1'b0, 1'b0, 2'b00, 1'b0, 2'd0, 32'hBAD1);
    check("nowen_no_strobe", REG_WR, 1'b1);
    send(5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0);
    check("r0_load_ready", bus.in_ready, 1'b1);
    check("r0_load_busy", busy, 1'b0);

    // Load accepted during COMMIT: current strobe, then WAIT_MEM.
    send(5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'h4444_4444);
    send(5'd6, 1'b1, 1'b1, 2'b10, 1'b1, 2'd1, 32'h0);
    check("commit_ld_release", REG_WR, 1'b1);
    check("commit_ld_hold_dir", DIR_WRA, 5'd4);
    give_mem(32'h0000_AB00, 1);
    check("commit_ld_di", DI, 32'h0000_00AB);
    tick();

    // Reset while waiting for load data discards the write.
    send(5'd8, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0);
    tick();
    check("pre_rst_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_reg_wr", REG_WR, 1'b1);
    check("midrst_di", DI, 32'd0);
    check("midrst_ready", bus.in_ready, 1'b1);
    bus.mem_data_valid = 1'b1;
    tick();
    bus.mem_data_valid = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    check("post_rst_busy", busy, 1'b0);

`ifdef WB_TIMEOUT_EN
    // Load with no data: abort after 16 waiting cycles, sticky error.
    send(5'd12, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      check("tmo_waiting", bus.in_ready, 1'b0);
      tick();
    end
    check("tmo_last_wait", busy, 1'b1);
    check("tmo_err_low", wb_err, 1'b0);
    tick();
    check("tmo_idle", busy, 1'b0);
    check("tmo_err", wb_err, 1'b1);
    check("tmo_no_strobe", REG_WR, 1'b1);
    tick();
    check("tmo_err_sticky", wb_err, 1'b1);
`else
    // Without the timeout option the stage waits indefinitely.
    send(5'd12, 1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 32'h0);
    give_mem(32'h1357_9BDF, 20);
    check("long_wait_di", DI, 32'h1357_9BDF);
    check("no_err", wb_err, 1'b0);
    tick();
`endif

    // Random traffic against the expected-write queue.
    for (int n = 0; n < 150; n++) begin
      rd   = 5'($urandom_range(0, 31));
      wen  = ($urandom_range(0, 7) != 0);
      m2r  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      off  = 2'($urandom_range(0, 3));
      send(rd, wen, m2r, size, uns, off, $urandom);
      if (!wen || rd == 5'd0) begin
        check("rnd_silent", REG_WR, 1'b1);
      end else if (m2r) begin
        give_mem($urandom, $urandom_range(0, 3));
      end else begin
        check("rnd_alu_strobe", REG_WR, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick(); tick();

    check("queue_empty", exp_q.size(), 0);
    check("strobe_count", strobes, exp_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Write-back stage of the single-cycle-to-pipelined MIPS datapath and the write side of the decode-stage register bank. It accepts retiring instructions from the memory stage and waits for load data when needed. It aligns and extends sub-word loads, then drives the bank's write port (`DIR_WRA`, `DI`, active-low `REG_WR`) for exactly one cycle per committed write. It also exposes a same-cycle bypass so decode can see a value being written in the current cycle.

## Interface
- `DATA_W`, 32, datapath width
- `ADDR_W`, 5, register address width
- `reloj`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  memory stage presents a retiring instruction
- `in_ready`  out  1  stage can accept; transfer when `in_valid & in_ready`
- `in_rd`  in  ADDR_W  destination register
- `in_wen`  in  1  instruction writes a register (active-high)
- `in_mem_to_reg`  in  1  result comes from memory, not ALU
- `in_ld_size`  in  2  00 word, 01 half, 10 byte, 11 treated as word
- `in_ld_unsigned`  in  1  zero-extend sub-word load (else sign-extend)
- `in_byte_off`  in  2  address bits [1:0] of the load
- `in_alu`  in  DATA_W  ALU result
- `mem_data_valid`  in  1  load data valid this cycle
- `mem_data`  in  DATA_W  load data word
- `DIR_WRA`  out  ADDR_W  write address to register bank
- `DI`  out  DATA_W  write data to register bank
- `REG_WR`  out  1  write strobe, active-low (0 = write)
- `fwd_valid`, `fwd_dir`, `fwd_data`  out  1/ADDR_W/DATA_W  bypass of the current write
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - WAIT_MEM: `in_ready`=0.
  - COMMIT: `in_ready`=1.
- On accept (IDLE or COMMIT):
  - `in_wen`=0 or `in_rd`=0: retire silently. Next state is IDLE, no strobe.
  - ALU result: latch `in_rd` and `in_alu`. Next state is COMMIT.
  - Load (`in_mem_to_reg`=1): latch `in_rd`, size, unsigned flag and offset. Next state is WAIT_MEM.
- WAIT_MEM:
  - `mem_data_valid` is sampled only in this state.
  - When it is high, latch the aligned/extended data and go to COMMIT.
  - Otherwise stay in WAIT_MEM.
- COMMIT:
  - `REG_WR`=0 with latched `DIR_WRA`/`DI`. `fwd_valid`=1, `fwd_dir`=`DIR_WRA`, `fwd_data`=`DI`.
  - Without a new accept, the next state is IDLE.
- Alignment is little-endian:
  - byte: lane `in_byte_off`, i.e. off 0 → `mem_data`[7:0].
  - half: off[1]=0 → [15:0], off[1]=1 → [31:16]. off[0] is ignored.
  - word: `in_byte_off` is ignored.
  - Sub-word values are extended to DATA_W: zero-extended if `in_ld_unsigned`, sign-extended otherwise.
- Outside COMMIT: `REG_WR`=1 and `fwd_valid`=0. `DI`/`DIR_WRA` hold their last values.

## Timing
- Reset values: state IDLE, `REG_WR`=1, `DI`=0, `DIR_WRA`=0, `fwd_valid`=0, `fwd_data`=0, `fwd_dir`=0, `busy`=0, `in_ready`=1, `wb_err`=0.
- ALU op accepted in cycle N → `REG_WR` low in N+1. The bank captures the value at the edge ending N+1.
- Load accepted in N with data valid in M ≥ N+1 → `REG_WR` low in M+1.
- Back-to-back ALU ops give one strobe per cycle with no bubble. Accepting a load in COMMIT gives a strobe for the current op, then WAIT_MEM.
- `mem_data_valid` in the accept cycle is ignored; memory must present data at least one cycle later.
- Reset asserted mid-operation: the pending write is discarded and no strobe is issued. Outputs go to reset values immediately.
- The strobe is never issued for register 0.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - A 4-bit counter runs in WAIT_MEM and clears on entry.
  - If 16 cycles pass without `mem_data_valid`, the load is aborted, with no strobe, and the FSM returns to IDLE.
  - The sticky output `wb_err` (1 bit) is set. It is cleared only by reset.
- `WB_TIMEOUT_EN` undefined: WAIT_MEM waits indefinitely. `wb_err` is tied to 0.

## Structure
- Package `wb_pkg`: state encoding (IDLE, WAIT_MEM, COMMIT), load-size codes (LD_WORD, LD_HALF, LD_BYTE), default DATA_W/ADDR_W, timeout limit (16).
- Sub-module `load_align`: combinational lane select plus sign/zero extension. Inputs are data, size, offset and unsigned; output is DATA_W.
- Top level holds the FSM, the latched fields, the timeout counter and the output registers.

## Test plan
- Reset release, then ALU op `in_rd`=5, `in_alu`=0x1234_5678 → one cycle later `REG_WR`=0, `DIR_WRA`=5, `DI`=0x1234_5678, `fwd_valid`=1; the next cycle `REG_WR`=1.
- Signed byte load, off=2, `mem_data`=0x0080_0000, valid 3 cycles after accept → `DI`=0xFFFF_FF80. The unsigned variant gives 0x0000_0080. `in_ready`=0 while waiting.
- Half load, off=2, signed, `mem_data`=0x8001_7FFF → `DI`=0xFFFF_8001. Word load with off=3 and `mem_data`=0xDEAD_BEEF → `DI`=0xDEAD_BEEF.
- Three back-to-back ALU ops to r1, r2, r3 → three consecutive `REG_WR` low cycles with matching addresses. Ops to r0 or with `in_wen`=0 → no strobe.
- Reset asserted while in WAIT_MEM → no strobe, `busy`=0. With `WB_TIMEOUT_EN`, a load with no data → `wb_err`=1 after 16 cycles and the FSM returns to IDLE.
